// File: rtl/universal_register.sv
// universal_register: WIDTH-bit register with clear, load, shift, rotate and up/down count modes
module universal_register #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             wrap,
  output logic             zero
);
  logic [WIDTH-1:0] q_n;
  logic so_n, w_n;
  always_comb begin
    q_n = Q;
    so_n = serial_out;
    w_n = 1'b0;
    if (en)
      case (mode)
        3'b001: begin q_n = {Q[WIDTH-2:0], serial_in}; so_n = Q[WIDTH-1]; end
        3'b010: begin q_n = {serial_in, Q[WIDTH-1:1]}; so_n = Q[0]; end
        3'b011: begin q_n = {Q[WIDTH-1], Q[WIDTH-1:1]}; so_n = Q[0]; end
        3'b100: begin q_n = {Q[WIDTH-2:0], Q[WIDTH-1]}; so_n = Q[WIDTH-1]; end
        3'b101: begin q_n = {Q[0], Q[WIDTH-1:1]}; so_n = Q[0]; end
        3'b110: begin q_n = Q + 1'b1; w_n = &Q; end
        3'b111: begin q_n = Q - 1'b1; w_n = ~|Q; end
        default: q_n = Q;
      endcase
  end
  always_ff @(posedge clk)
    if (!clr) begin
      Q <= RESET_VALUE;
      serial_out <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      Q <= data;
      wrap <= 1'b0;
    end else begin
      Q <= q_n;
      serial_out <= so_n;
      wrap <= w_n;
    end
  assign zero = ~|Q;
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: vector table plus randomized reference-model check of universal_register
module tb_universal_register;
  logic clk = 1'b0;
  logic clr, load, en, serial_in;
  logic [7:0] data;
  logic [2:0] mode;
  logic [7:0] q;
  logic serial_out, wrap, zero;
  int checks = 0, errors = 0;

  universal_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .clr(clr), .load(load), .data(data), .en(en), .mode(mode),
    .serial_in(serial_in), .Q(q), .serial_out(serial_out), .wrap(wrap), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr, load;
    logic [7:0] data;
    logic en;
    logic [2:0] mode;
    logic si;
    logic [7:0] eq;
    logic eso, ew, ez;
  } vec_t;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [7:0] d, input logic e, input logic [2:0] m, input logic s);
    clr = c; load = l; data = d; en = e; mode = m; serial_in = s;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[$];
  int mq, mso, mw;

  initial begin
    vt = '{
      '{0,1,8'h3C,0,3'd0,0, 8'hA5,0,0,0},
      '{1,1,8'h81,0,3'd0,0, 8'h81,0,0,0},
      '{1,0,8'h00,1,3'd1,0, 8'h02,1,0,0},
      '{1,0,8'h00,1,3'd1,0, 8'h04,0,0,0},
      '{1,1,8'h80,0,3'd0,0, 8'h80,0,0,0},
      '{1,0,8'h00,1,3'd3,1, 8'hC0,0,0,0},
      '{1,0,8'h00,1,3'd3,1, 8'hE0,0,0,0},
      '{1,0,8'h00,1,3'd3,1, 8'hF0,0,0,0},
      '{1,0,8'h00,1,3'd2,0, 8'h78,0,0,0},
      '{1,1,8'hFE,0,3'd0,0, 8'hFE,0,0,0},
      '{1,0,8'h00,1,3'd6,0, 8'hFF,0,0,0},
      '{1,0,8'h00,1,3'd6,0, 8'h00,0,1,1},
      '{1,0,8'h00,1,3'd6,0, 8'h01,0,0,0},
      '{1,1,8'h01,0,3'd0,0, 8'h01,0,0,0},
      '{1,0,8'h00,1,3'd7,0, 8'h00,0,0,1},
      '{1,0,8'h00,1,3'd7,0, 8'hFF,0,1,0},
      '{1,1,8'h01,0,3'd0,0, 8'h01,0,0,0},
      '{1,0,8'h00,1,3'd5,0, 8'h80,1,0,0},
      '{1,1,8'h0F,0,3'd0,0, 8'h0F,1,0,0},
      '{1,0,8'h00,1,3'd6,0, 8'h10,1,0,0},
      '{0,0,8'h00,1,3'd6,0, 8'hA5,0,0,0},
      '{1,1,8'hFF,1,3'd6,0, 8'hFF,0,0,0},
      '{1,0,8'h00,1,3'd6,0, 8'h00,0,1,1},
      '{1,1,8'h33,1,3'd6,0, 8'h33,0,0,0},
      '{1,0,8'h00,0,3'd1,1, 8'h33,0,0,0},
      '{1,0,8'h00,1,3'd4,0, 8'h66,0,0,0},
      '{1,0,8'h00,1,3'd0,1, 8'h66,0,0,0}
    };
    @(negedge clk);
    foreach (vt[i]) begin
      drive(vt[i].clr, vt[i].load, vt[i].data, vt[i].en, vt[i].mode, vt[i].si);
      chk("q", i, q, vt[i].eq);
      chk("serial_out", i, {7'd0, serial_out}, {7'd0, vt[i].eso});
      chk("wrap", i, {7'd0, wrap}, {7'd0, vt[i].ew});
      chk("zero", i, {7'd0, zero}, {7'd0, vt[i].ez});
    end
    mq = 'hA5; mso = 0; mw = 0;
    drive(0, 0, 8'h00, 0, 3'd0, 0);
    for (int i = 0; i < 400; i++) begin
      logic c, l, e, s;
      logic [7:0] d;
      logic [2:0] m;
      c = ($urandom_range(0, 31) != 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 5) != 0);
      d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      m = 3'($urandom);
      s = 1'($urandom);
      drive(c, l, d, e, m, s);
      if (!c) begin
        mq = 'hA5; mso = 0; mw = 0;
      end else if (l) begin
        mq = d; mw = 0;
      end else begin
        mw = 0;
        if (e)
          case (m)
            3'd1: begin mso = mq / 128; mq = (mq * 2 + s) % 256; end
            3'd2: begin mso = mq % 2; mq = mq / 2 + s * 128; end
            3'd3: begin mso = mq % 2; mq = mq / 2 + (mq / 128) * 128; end
            3'd4: begin mso = mq / 128; mq = (mq * 2) % 256 + mq / 128; end
            3'd5: begin mso = mq % 2; mq = mq / 2 + (mq % 2) * 128; end
            3'd6: begin mw = (mq == 255); mq = (mq + 1) % 256; end
            3'd7: begin mw = (mq == 0); mq = (mq + 255) % 256; end
            default: ;
          endcase
      end
      chk("rand_q", i, q, 8'(mq));
      chk("rand_serial_out", i, {7'd0, serial_out}, 8'(mso));
      chk("rand_wrap", i, {7'd0, wrap}, 8'(mw));
      chk("rand_zero", i, {7'd0, zero}, 8'(mq == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
